// File: rtl/aes_rs_seq.sv
// Sequencer for a byte-serial AES-256 core. For each block it resets the core,
// streams the key and state bytes MSB-first, starts the core, and returns the result or a timeout.
module aes_rs_seq #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic         key_we,
  input  logic         blk_valid,
  input  logic [127:0] blk_in,
  output logic         blk_ready,
  output logic         res_valid,
  output logic [127:0] res_data,
  output logic         res_err,
  input  logic         res_ready,
  output logic         busy,
  output logic         core_rst_n,
  output logic         c_ld_key_valid,
  output logic [7:0]   c_ld_key_byte,
  input  logic         c_ld_key_ready,
  output logic         c_ld_state_valid,
  output logic [7:0]   c_ld_state_byte,
  input  logic         c_ld_state_ready,
  output logic         c_start,
  input  logic [127:0] c_state_out,
  input  logic         c_done
);

  typedef enum logic [2:0] {IDLE, CRST, LOAD, START, WAIT, OUT} state_t;

  localparam logic [9:0] TMO = 10'(TIMEOUT);

  state_t         state, state_nx;
  logic [255:0]   key_reg;
  logic           key_loaded;
  logic [127:0]   blk_reg;
  logic [5:0]     kcnt;
  logic [4:0]     scnt;
  logic [9:0]     wcnt;
  logic           crst_cnt;
  logic [4:0]     kidx;
  logic [3:0]     sidx;
  logic           blk_acc;
  logic           key_hs;
  logic           st_hs;

  assign busy             = (state != IDLE);
  assign blk_ready        = (state == IDLE) && key_loaded && !key_we;
  assign blk_acc          = blk_valid && blk_ready;
  assign c_ld_key_valid   = (state == LOAD) && (kcnt < 6'd32);
  assign c_ld_state_valid = (state == LOAD) && (scnt < 5'd16);
  assign key_hs           = c_ld_key_valid && c_ld_key_ready;
  assign st_hs            = c_ld_state_valid && c_ld_state_ready;

  // Byte 0 lives in the top bits, so the counters index down from the MSB end
  assign kidx            = 5'd31 - kcnt[4:0];
  assign sidx            = 4'd15 - scnt[3:0];
  assign c_ld_key_byte   = key_reg[{kidx, 3'b000} +: 8];
  assign c_ld_state_byte = blk_reg[{sidx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (blk_acc) state_nx = CRST;
      CRST:    if (crst_cnt) state_nx = LOAD;
      // Uses registered counts, so START always follows the last handshake by a cycle
      LOAD:    if (kcnt == 6'd32 && scnt == 5'd16) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (c_done || wcnt == TMO) state_nx = OUT;
      OUT:     if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg    <= '0;
      key_loaded <= 1'b0;
      blk_reg    <= '0;
    end else begin
      if (state == IDLE && key_we) begin
        key_reg    <= key_in;
        key_loaded <= 1'b1;
      end
      if (blk_acc) blk_reg <= blk_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcnt       <= '0;
      scnt       <= '0;
      crst_cnt   <= 1'b0;
      core_rst_n <= 1'b0;
      c_start    <= 1'b0;
    end else begin
      if (blk_acc) begin
        kcnt       <= '0;
        scnt       <= '0;
        crst_cnt   <= 1'b0;
        core_rst_n <= 1'b0;
      end else begin
        if (state == CRST) begin
          crst_cnt <= 1'b1;
          if (crst_cnt) core_rst_n <= 1'b1;
        end
        if (key_hs) kcnt <= kcnt + 6'd1;
        if (st_hs)  scnt <= scnt + 5'd1;
      end
      c_start <= (state_nx == START);
    end
  end

  // c_done is tested first so a completion on the timeout cycle still counts as success
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      if (state == START) wcnt <= '0;
      if (state == WAIT) begin
        if (c_done) begin
          res_data  <= c_state_out;
          res_err   <= 1'b0;
          res_valid <= 1'b1;
        end else if (wcnt == TMO) begin
          res_data  <= '0;
          res_err   <= 1'b1;
          res_valid <= 1'b1;
        end else begin
          wcnt <= wcnt + 10'd1;
        end
      end
      if (state == OUT && res_ready) res_valid <= 1'b0;
    end
  end

endmodule
